char_loader: RTL and testbench

- Upstream feeder for the 4x5 1-bit character bitmap memory.
- Receives a glyph bitmap from the Arduino over a 3-wire serial link (chip-select, serial clock, serial data), one bit per serial clock edge.
- Converts each received bit into a single-cycle write strobe with cell coordinates (x, y) and data, matching that memory's write port.
- Reports frame completion or error status to the surrounding control logic.

---
 rtl/char_loader_pkg.sv | 14 +
 rtl/char_loader_sync_edge.sv | 35 +++
 rtl/char_loader.sv | 173 +++++++++++++++++
 tb/tb_char_loader.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/char_loader_pkg.sv
// Shared definitions for the character loader and the 4x5 character bitmap memory.
package char_loader_pkg;

   localparam int unsigned CHAR_COLS = 4;
   localparam int unsigned CHAR_ROWS = 5;
   localparam int unsigned CHAR_BITS = CHAR_COLS * CHAR_ROWS;

   typedef enum logic [1:0] {
      IDLE,
      RECV,
      FULL
   } loader_state_t;

endpackage

// File: rtl/char_loader_sync_edge.sv
// N-stage synchronizer for one asynchronous input, with registered rise/fall pulses.
module sync_edge #(
   parameter int unsigned STAGES    = 2,
   parameter logic        RESET_VAL = 1'b0
) (
   input  logic clock,
   input  logic rst_n,
   input  logic din,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync_q;
   logic              prev_q;
   logic              rise_q;
   logic              fall_q;

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= {STAGES{RESET_VAL}};
         prev_q <= RESET_VAL;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], din};
         prev_q <= sync_q[STAGES-1];
         rise_q <= sync_q[STAGES-1] & ~prev_q;
         fall_q <= ~sync_q[STAGES-1] & prev_q;
      end
   end

   assign rise = rise_q;
   assign fall = fall_q;

endmodule

// File: rtl/char_loader.sv
// Serial glyph receiver: turns each received bit into a write strobe for the char memory.
module char_loader
   import char_loader_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned COLS        = CHAR_COLS,
   parameter int unsigned ROWS        = CHAR_ROWS
) (
   input  logic       clock,
   input  logic       rst_n,
   input  logic       ser_cs_n,
   input  logic       ser_clk,
   input  logic       ser_data,
   output logic       mem_write,
   output logic [1:0] mem_x,
   output logic [2:0] mem_y,
   output logic       mem_data,
   output logic       busy,
   output logic       frame_done,
   output logic       frame_error
);

   localparam int unsigned CNT_W = $clog2(COLS * ROWS + 1);

   logic cs_rise, cs_fall, clk_rise, clk_fall_unused;
   logic [SYNC_STAGES-1:0] data_sync_q;
   logic data_al_q;

   loader_state_t state_q, state_d;
   logic [1:0]       x_cnt_q, x_cnt_d;
   logic [2:0]       y_cnt_q, y_cnt_d;
   logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic             ovf_q, ovf_d;
   logic             write_q, write_d, data_q, data_d, busy_q;
   logic             done_q, done_d, err_q, err_d;
   logic [1:0]       mx_q, mx_d;
   logic [2:0]       my_q, my_d;
   logic             last_cell;

   sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
      .clock (clock),
      .rst_n (rst_n),
      .din   (ser_cs_n),
      .rise  (cs_rise),
      .fall  (cs_fall)
   );

   sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_clk_sync (
      .clock (clock),
      .rst_n (rst_n),
      .din   (ser_clk),
      .rise  (clk_rise),
      .fall  (clk_fall_unused)
   );

   // Extra flop keeps the data bit in step with the registered clk_rise pulse.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         data_sync_q <= '0;
         data_al_q   <= 1'b0;
      end else begin
         data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ser_data};
         data_al_q   <= data_sync_q[SYNC_STAGES-1];
      end
   end

   assign last_cell = (x_cnt_q == 2'(COLS - 1)) && (y_cnt_q == 3'(ROWS - 1));

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (cs_fall) state_d = RECV;
         RECV: begin
            if (cs_rise)                    state_d = IDLE;
            else if (clk_rise && last_cell) state_d = FULL;
         end
         FULL: if (cs_rise) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      x_cnt_d   = x_cnt_q;
      y_cnt_d   = y_cnt_q;
      bit_cnt_d = bit_cnt_q;
      ovf_d     = ovf_q;
      write_d   = 1'b0;
      mx_d      = mx_q;
      my_d      = my_q;
      data_d    = data_q;
      done_d    = 1'b0;
      err_d     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (cs_fall) begin
               x_cnt_d   = '0;
               y_cnt_d   = '0;
               bit_cnt_d = '0;
               ovf_d     = 1'b0;
            end
         end
         RECV: begin
            // A cs_n rise wins over a coincident ser_clk rise; that bit is dropped.
            if (cs_rise) begin
               err_d = 1'b1;
            end else if (clk_rise) begin
               write_d   = 1'b1;
               mx_d      = x_cnt_q;
               my_d      = y_cnt_q;
               data_d    = data_al_q;
               bit_cnt_d = bit_cnt_q + CNT_W'(1);
               if (x_cnt_q == 2'(COLS - 1)) begin
                  x_cnt_d = '0;
                  if (y_cnt_q != 3'(ROWS - 1)) y_cnt_d = y_cnt_q + 3'd1;
               end else begin
                  x_cnt_d = x_cnt_q + 2'd1;
               end
            end
         end
         FULL: begin
            if (cs_rise) begin
               done_d = ~ovf_q;
               err_d  = ovf_q;
            end else if (clk_rise) begin
               ovf_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         x_cnt_q   <= '0;
         y_cnt_q   <= '0;
         bit_cnt_q <= '0;
         ovf_q     <= 1'b0;
         write_q   <= 1'b0;
         mx_q      <= '0;
         my_q      <= '0;
         data_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         x_cnt_q   <= x_cnt_d;
         y_cnt_q   <= y_cnt_d;
         bit_cnt_q <= bit_cnt_d;
         ovf_q     <= ovf_d;
         write_q   <= write_d;
         mx_q      <= mx_d;
         my_q      <= my_d;
         data_q    <= data_d;
         busy_q    <= (state_d != IDLE);
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   assign mem_write   = write_q;
   assign mem_x       = mx_q;
   assign mem_y       = my_q;
   assign mem_data    = data_q;
   assign busy        = busy_q;
   assign frame_done  = done_q;
   assign frame_error = err_q;

endmodule

// File: tb/tb_char_loader.sv
// Directed bench for char_loader with a write scoreboard.
module tb_char_loader;

   logic       clock = 1'b0;
   logic       rst_n = 1'b0;
   logic       ser_cs_n = 1'b1;
   logic       ser_clk = 1'b0;
   logic       ser_data = 1'b0;
   logic       mem_write;
   logic [1:0] mem_x;
   logic [2:0] mem_y;
   logic       mem_data;
   logic       busy;
   logic       frame_done;
   logic       frame_error;

   int n_cmp = 0;
   int n_fail = 0;
   int n_wr = 0;
   int n_done = 0;
   int n_err = 0;
   int k = 0;
   logic [5:0] exp_q[$];
   logic [19:0] pat;

   char_loader dut (
      .clock       (clock),
      .rst_n       (rst_n),
      .ser_cs_n    (ser_cs_n),
      .ser_clk     (ser_clk),
      .ser_data    (ser_data),
      .mem_write   (mem_write),
      .mem_x       (mem_x),
      .mem_y       (mem_y),
      .mem_data    (mem_data),
      .busy        (busy),
      .frame_done  (frame_done),
      .frame_error (frame_error)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every write is popped against the bench's expected (x, y, data).
   always @(negedge clock) begin
      if (rst_n) begin
         if (mem_write) begin
            logic [5:0] e;
            n_wr++;
            check("wr_y_range", 32'(mem_y < 3'd5), 32'd1);
            check("wr_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("wr_xyd", {26'd0, mem_x, mem_y, mem_data}, {26'd0, e});
            end
         end
         if (frame_done) n_done++;
         if (frame_error) n_err++;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clock);
      #2;
   endtask

   task automatic clear_counts();
      n_wr = 0;
      n_done = 0;
      n_err = 0;
      k = 0;
   endtask

   task automatic start_frame();
      clear_counts();
      ser_cs_n = 1'b0;
      cyc(6);
   endtask

   task automatic send_bit(input logic b);
      if (k < 20) exp_q.push_back({2'(k % 4), 3'(k / 4), b});
      k++;
      ser_data = b;
      cyc(2);
      ser_clk = 1'b1;
      cyc(5);
      ser_clk = 1'b0;
      cyc(5);
   endtask

   task automatic end_frame();
      ser_cs_n = 1'b1;
      cyc(8);
   endtask

   task automatic frame_checks(input string tag, input int wr, input int done, input int err);
      check({tag, "_writes"}, 32'(n_wr), 32'(wr));
      check({tag, "_done"}, 32'(n_done), 32'(done));
      check({tag, "_error"}, 32'(n_err), 32'(err));
      check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
      check({tag, "_busy_low"}, 32'(busy), 32'd0);
   endtask

   initial begin
      pat = 20'hA5A5A;
      #1;
      check("reset_outputs", {25'd0, mem_write, mem_x, mem_y, mem_data, busy, frame_done,
                              frame_error}, 32'd0);
      cyc(3);
      rst_n = 1'b1;
      cyc(4);

      // Full frame, MSB first
      start_frame();
      check("full_busy_high", 32'(busy), 32'd1);
      for (int i = 19; i >= 0; i--) send_bit(pat[i]);
      end_frame();
      frame_checks("full", 20, 1, 0);

      // Short frame: 7 bits
      start_frame();
      for (int i = 0; i < 7; i++) send_bit(1'(i & 1));
      check("short_last_xy", {27'd0, mem_x, mem_y}, {27'd0, 2'd2, 3'd1});
      end_frame();
      frame_checks("short", 7, 0, 1);

      // Long frame: 23 bits, only 20 written
      start_frame();
      for (int i = 0; i < 23; i++) send_bit(1'(i % 3 == 0));
      end_frame();
      frame_checks("long", 20, 0, 1);

      // Reset mid-frame
      start_frame();
      for (int i = 0; i < 9; i++) send_bit(1'b1);
      check("mid_busy_before_reset", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("mid_reset_outputs", {25'd0, mem_write, mem_x, mem_y, mem_data, busy, frame_done,
                                  frame_error}, 32'd0);
      ser_cs_n = 1'b1;
      cyc(3);
      rst_n = 1'b1;
      cyc(4);
      check("mid_writes_before", 32'(n_wr), 32'd9);
      start_frame();
      for (int i = 0; i < 20; i++) send_bit(1'(i < 10));
      end_frame();
      frame_checks("after_reset", 20, 1, 0);

      // Simultaneous 20th ser_clk rise and cs_n rise
      start_frame();
      for (int i = 0; i < 19; i++) send_bit(1'(i & 1));
      ser_data = 1'b1;
      cyc(2);
      ser_clk = 1'b1;
      ser_cs_n = 1'b1;
      cyc(5);
      ser_clk = 1'b0;
      cyc(8);
      frame_checks("simul", 19, 0, 1);

      // Stray ser_clk with cs_n high
      clear_counts();
      for (int i = 0; i < 5; i++) begin
         ser_clk = 1'b1;
         cyc(5);
         ser_clk = 1'b0;
         cyc(5);
      end
      frame_checks("stray", 0, 0, 0);

      // Back-to-back frames: cs_n fall right after the rise
      start_frame();
      for (int i = 0; i < 20; i++) send_bit(pat[i]);
      ser_cs_n = 1'b1;
      cyc(1);
      ser_cs_n = 1'b0;
      cyc(8);
      check("b2b_done", 32'(n_done), 32'd1);
      check("b2b_busy_high", 32'(busy), 32'd1);
      clear_counts();
      for (int i = 0; i < 20; i++) send_bit(~pat[i]);
      end_frame();
      frame_checks("b2b_second", 20, 1, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
